// File: rtl/hazard_scoreboard_if.sv
// Issue-stage bundle and scoreboard decisions exchanged between the issue
// logic (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int LANES      = 2,
  parameter int REG_W      = 5,
  parameter int FWD_STAGES = 3
);
  localparam int FSEL_W = $clog2(FWD_STAGES * LANES + 1);
  localparam int ML_W   = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]        issue_valid;
  logic [LANES*REG_W-1:0]  issue_rs1;
  logic [LANES*REG_W-1:0]  issue_rs2;
  logic [LANES*REG_W-1:0]  issue_rd;
  logic [LANES-1:0]        issue_rd_we;
  logic [LANES-1:0]        issue_is_load;
  logic [LANES-1:0]        issue_is_store;
  logic [LANES-1:0]        issue_is_branch;
  logic                    mispredict;
  logic [ML_W-1:0]         mispredict_lane;

  logic [LANES-1:0]        issue_grant;
  logic                    stall_front;
  logic [LANES*FSEL_W-1:0] fwd_sel_rs1;
  logic [LANES*FSEL_W-1:0] fwd_sel_rs2;
  logic                    flush_dec;
  logic                    flush_issue;
  logic [31:0]             stall_cycles;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
           issue_is_load, issue_is_store, issue_is_branch,
           mispredict, mispredict_lane,
    input  issue_grant, stall_front, fwd_sel_rs1, fwd_sel_rs2,
           flush_dec, flush_issue, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
           issue_is_load, issue_is_store, issue_is_branch,
           mispredict, mispredict_lane,
    output issue_grant, stall_front, fwd_sel_rs1, fwd_sel_rs2,
           flush_dec, flush_issue, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Multi-lane hazard scoreboard: in-order grant prefix, operand forwarding
// selects, load-use/structural stalls and a two-cycle mispredict flush.
module hazard_scoreboard #(
  parameter int LANES      = 2,
  parameter int REG_W      = 5,
  parameter int FWD_STAGES = 3,
  parameter int MEM_PORTS  = 1,
  parameter int BR_PORTS   = 1,
  parameter int FSEL_W     = $clog2(FWD_STAGES * LANES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int ML_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic src_hit(entry_t e, logic [REG_W-1:0] src);
    return e.v && e.we && (e.rd == src) && (src != '0);
  endfunction

  entry_t           sh_q     [FWD_STAGES][LANES];
  entry_t           sh0_kill [LANES];
  state_t           state_q, state_d;
  logic             flush;
  logic             mp_kill;
  logic [LANES-1:0] raw_grant;
  logic [LANES-1:0] grant;
  logic             stall_front;
  logic [31:0]      stall_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    state_d = state_q;
    flush   = 1'b0;
    mp_kill = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (bus.mispredict) begin
            state_d = FLUSH;
            flush   = 1'b1;
            mp_kill = 1'b1;
          end
        end
        FLUSH: begin
          state_d = RUN;
          flush   = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // --------------------------------------------------------------- grant
  always_comb begin : grant_calc
    logic             blocked;
    logic             hazard;
    logic             is_mem;
    int               mem_cnt;
    int               br_cnt;
    entry_t           prod;
    logic [REG_W-1:0] s1;
    logic [REG_W-1:0] s2;
    blocked   = 1'b0;
    hazard    = 1'b0;
    is_mem    = 1'b0;
    mem_cnt   = 0;
    br_cnt    = 0;
    prod      = '0;
    s1        = '0;
    s2        = '0;
    raw_grant = '0;
    for (int i = 0; i < LANES; i++) begin
      s1     = bus.issue_rs1[i*REG_W +: REG_W];
      s2     = bus.issue_rs2[i*REG_W +: REG_W];
      hazard = 1'b0;
      // Older lanes of the same bundle cannot forward to younger ones.
      for (int j = 0; j < i; j++) begin
        prod = '{v: 1'b1, rd: bus.issue_rd[j*REG_W +: REG_W],
                 we: bus.issue_rd_we[j], ld: 1'b0};
        if (src_hit(prod, s1) || src_hit(prod, s2)) hazard = 1'b1;
      end
      // A load in Ex has no data yet.
      for (int l = 0; l < LANES; l++) begin
        if (sh_q[0][l].ld && (src_hit(sh_q[0][l], s1) || src_hit(sh_q[0][l], s2)))
          hazard = 1'b1;
      end
      is_mem = bus.issue_is_load[i] | bus.issue_is_store[i];
      if (!bus.issue_valid[i] || hazard ||
          (mem_cnt + int'(is_mem) > MEM_PORTS) ||
          (br_cnt + int'(bus.issue_is_branch[i]) > BR_PORTS))
        blocked = 1'b1;
      if (!blocked) begin
        raw_grant[i] = 1'b1;
        mem_cnt      = mem_cnt + int'(is_mem);
        br_cnt       = br_cnt + int'(bus.issue_is_branch[i]);
      end
    end
  end

  // Mispredict and reset override every stall decision.
  always_comb begin
    grant       = raw_grant;
    stall_front = 1'b0;
    if (rst || flush) grant = '0;
    else              stall_front = (|bus.issue_valid) && (raw_grant != bus.issue_valid);
  end

  assign bus.issue_grant  = grant;
  assign bus.stall_front  = stall_front;
  assign bus.flush_dec    = flush;
  assign bus.flush_issue  = flush;
  assign bus.stall_cycles = stall_q;

  // ---------------------------------------------------------- forwarding
  always_comb begin : fwd_calc
    logic [FSEL_W-1:0] sel1;
    logic [FSEL_W-1:0] sel2;
    logic [REG_W-1:0]  s1;
    logic [REG_W-1:0]  s2;
    sel1            = '0;
    sel2            = '0;
    s1              = '0;
    s2              = '0;
    bus.fwd_sel_rs1 = '0;
    bus.fwd_sel_rs2 = '0;
    for (int i = 0; i < LANES; i++) begin
      s1   = bus.issue_rs1[i*REG_W +: REG_W];
      s2   = bus.issue_rs2[i*REG_W +: REG_W];
      sel1 = '0;
      sel2 = '0;
      if (grant[i]) begin
        // Scan oldest to youngest so the youngest producer overwrites.
        for (int s = FWD_STAGES - 1; s >= 0; s--) begin
          for (int l = 0; l < LANES; l++) begin
            if (!(s == 0 && sh_q[s][l].ld)) begin
              if (src_hit(sh_q[s][l], s1)) sel1 = FSEL_W'(1 + s * LANES + l);
              if (src_hit(sh_q[s][l], s2)) sel2 = FSEL_W'(1 + s * LANES + l);
            end
          end
        end
      end
      bus.fwd_sel_rs1[i*FSEL_W +: FSEL_W] = sel1;
      bus.fwd_sel_rs2[i*FSEL_W +: FSEL_W] = sel2;
    end
  end

  // -------------------------------------------------------------- shadow
  // Ex entries younger than the mispredicted branch are wrong-path.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sh0_kill[l] = sh_q[0][l];
      if (mp_kill && (ML_W'(l) > bus.mispredict_lane)) sh0_kill[l].v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow is a small flop array whose valid bits gate
      // stalls, so every entry is reset rather than left undefined.
      for (int s = 0; s < FWD_STAGES; s++)
        for (int l = 0; l < LANES; l++)
          sh_q[s][l] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        sh_q[0][l] <= '{v:  grant[l],
                        rd: bus.issue_rd[l*REG_W +: REG_W],
                        we: bus.issue_rd_we[l],
                        ld: bus.issue_is_load[l]};
        for (int s = 1; s < FWD_STAGES; s++)
          sh_q[s][l] <= (s == 1) ? sh0_kill[l] : sh_q[s-1][l];
      end
    end
  end

  // --------------------------------------------------------- stall count
  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (state_q == RUN && stall_front && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: a 2-lane/3-stage scoreboard for the main scenarios and a
// 4-lane/4-stage, 2-memory-port scoreboard for the wide configuration.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.LANES(2), .REG_W(5), .FWD_STAGES(3)) ifa ();
  hazard_scoreboard_if #(.LANES(4), .REG_W(5), .FWD_STAGES(4)) ifb ();

  hazard_scoreboard #(.LANES(2), .REG_W(5), .FWD_STAGES(3), .MEM_PORTS(1), .BR_PORTS(1))
    u_dut_a (.clk(clk), .rst(rst_a), .bus(ifa));

  hazard_scoreboard #(.LANES(4), .REG_W(5), .FWD_STAGES(4), .MEM_PORTS(2), .BR_PORTS(1))
    u_dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    ifa.issue_valid     = '0;
    ifa.issue_rs1       = '0;
    ifa.issue_rs2       = '0;
    ifa.issue_rd        = '0;
    ifa.issue_rd_we     = '0;
    ifa.issue_is_load   = '0;
    ifa.issue_is_store  = '0;
    ifa.issue_is_branch = '0;
    ifa.mispredict      = 1'b0;
    ifa.mispredict_lane = '0;
  endtask

  task automatic clear_b();
    ifb.issue_valid     = '0;
    ifb.issue_rs1       = '0;
    ifb.issue_rs2       = '0;
    ifb.issue_rd        = '0;
    ifb.issue_rd_we     = '0;
    ifb.issue_is_load   = '0;
    ifb.issue_is_store  = '0;
    ifb.issue_is_branch = '0;
    ifb.mispredict      = 1'b0;
    ifb.mispredict_lane = '0;
  endtask

  task automatic lane_a(input int l, input int rd, input int rs1, input int rs2,
                        input logic we, input logic ld, input logic st, input logic br);
    ifa.issue_valid[l]        = 1'b1;
    ifa.issue_rd[l*5 +: 5]    = 5'(rd);
    ifa.issue_rs1[l*5 +: 5]   = 5'(rs1);
    ifa.issue_rs2[l*5 +: 5]   = 5'(rs2);
    ifa.issue_rd_we[l]        = we;
    ifa.issue_is_load[l]      = ld;
    ifa.issue_is_store[l]     = st;
    ifa.issue_is_branch[l]    = br;
  endtask

  task automatic lane_b(input int l, input int rd, input int rs1, input int rs2,
                        input logic we, input logic ld, input logic st, input logic br);
    ifb.issue_valid[l]        = 1'b1;
    ifb.issue_rd[l*5 +: 5]    = 5'(rd);
    ifb.issue_rs1[l*5 +: 5]   = 5'(rs1);
    ifb.issue_rs2[l*5 +: 5]   = 5'(rs2);
    ifb.issue_rd_we[l]        = we;
    ifb.issue_is_load[l]      = ld;
    ifb.issue_is_store[l]     = st;
    ifb.issue_is_branch[l]    = br;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clear_a();
    clear_b();
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();

    // Reset: a valid instruction is never granted while rst is high.
    lane_a(0, 5, 1, 2, 1, 0, 0, 0);
    #1;
    check("rst_grant", 32'(ifa.issue_grant), 32'h0);
    check("rst_flush", 32'({ifa.flush_dec, ifa.flush_issue}), 32'h0);
    check("rst_count", ifa.stall_cycles, 32'h0);
    clear_a();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // add x5,x1,x2 ; sub x6,x5,x3 -> intra-bundle RAW blocks lane 1.
    lane_a(0, 5, 1, 2, 1, 0, 0, 0);
    lane_a(1, 6, 5, 3, 1, 0, 0, 0);
    #1;
    check("raw_grant", 32'(ifa.issue_grant), 32'h1);
    check("raw_stall", 32'(ifa.stall_front), 32'h1);
    check("raw_sel0", 32'(ifa.fwd_sel_rs1[2:0]), 32'h0);
    tick();

    // sub re-presented in lane 0, forwards from stage 0 lane 0.
    clear_a();
    lane_a(0, 6, 5, 3, 1, 0, 0, 0);
    #1;
    check("re_grant", 32'(ifa.issue_grant), 32'h1);
    check("re_stall", 32'(ifa.stall_front), 32'h0);
    check("re_sel_rs1", 32'(ifa.fwd_sel_rs1[2:0]), 32'h1);
    check("re_sel_rs2", 32'(ifa.fwd_sel_rs2[2:0]), 32'h0);
    check("re_count", ifa.stall_cycles, 32'h1);
    tick();

    // lw x7,0(x10)
    clear_a();
    lane_a(0, 7, 10, 0, 1, 1, 0, 0);
    #1;
    check("lw_grant", 32'(ifa.issue_grant), 32'h1);
    tick();

    // addi x8,x7,1 right behind the load -> load-use stall.
    clear_a();
    lane_a(0, 8, 7, 0, 1, 0, 0, 0);
    #1;
    check("lu_grant", 32'(ifa.issue_grant), 32'h0);
    check("lu_stall", 32'(ifa.stall_front), 32'h1);
    tick();
    #1;
    check("lu2_grant", 32'(ifa.issue_grant), 32'h1);
    check("lu2_sel", 32'(ifa.fwd_sel_rs1[2:0]), 32'h3);
    check("lu2_count", ifa.stall_cycles, 32'h2);
    tick();

    // Structural limits: one memory op and one branch per bundle.
    clear_a();
    lane_a(0, 11, 12, 0, 1, 1, 0, 0);
    lane_a(1, 13, 14, 0, 1, 1, 0, 0);
    #1;
    check("2ld_grant", 32'(ifa.issue_grant), 32'h1);
    check("2ld_stall", 32'(ifa.stall_front), 32'h1);
    clear_a();
    lane_a(0, 0, 1, 2, 0, 0, 0, 1);
    lane_a(1, 0, 3, 4, 0, 0, 0, 1);
    #1;
    check("2br_grant", 32'(ifa.issue_grant), 32'h1);
    clear_a();
    lane_a(0, 11, 12, 0, 1, 1, 0, 0);
    lane_a(1, 0, 15, 16, 0, 0, 1, 0);
    #1;
    check("ldst_grant", 32'(ifa.issue_grant), 32'h1);
    clear_a();
    lane_a(0, 11, 12, 0, 1, 1, 0, 0);
    lane_a(1, 0, 3, 4, 0, 0, 0, 1);
    #1;
    check("ldbr_grant", 32'(ifa.issue_grant), 32'h3);
    check("ldbr_stall", 32'(ifa.stall_front), 32'h0);
    clear_a();
    tick();

    // x9 producers: stage 2 lane 1 and stage 0 lane 0.
    lane_a(0, 20, 1, 2, 1, 0, 0, 0);
    lane_a(1, 9, 1, 2, 1, 0, 0, 0);
    #1;
    check("p1_grant", 32'(ifa.issue_grant), 32'h3);
    tick();
    clear_a();
    #1;
    check("idle_grant", 32'(ifa.issue_grant), 32'h0);
    check("idle_stall", 32'(ifa.stall_front), 32'h0);
    tick();
    lane_a(0, 9, 1, 2, 1, 0, 0, 0);
    #1;
    check("p2_grant", 32'(ifa.issue_grant), 32'h1);
    tick();
    clear_a();
    lane_a(0, 15, 9, 0, 1, 0, 0, 0);
    lane_a(1, 16, 0, 9, 1, 0, 0, 0);
    #1;
    check("yw_grant", 32'(ifa.issue_grant), 32'h3);
    check("yw_l0_rs1", 32'(ifa.fwd_sel_rs1[2:0]), 32'h1);
    check("yw_l0_rs2", 32'(ifa.fwd_sel_rs2[2:0]), 32'h0);
    check("yw_l1_rs1", 32'(ifa.fwd_sel_rs1[5:3]), 32'h0);
    check("yw_l1_rs2", 32'(ifa.fwd_sel_rs2[5:3]), 32'h1);
    check("yw_stall", 32'(ifa.stall_front), 32'h0);
    clear_a();
    tick();

    // Branch in lane 0, x4 writer in lane 1; branch mispredicts in Ex.
    lane_a(0, 0, 1, 2, 0, 0, 0, 1);
    lane_a(1, 4, 1, 2, 1, 0, 0, 0);
    #1;
    check("br_grant", 32'(ifa.issue_grant), 32'h3);
    tick();
    clear_a();
    lane_a(0, 21, 1, 2, 1, 0, 0, 0);
    ifa.mispredict      = 1'b1;
    ifa.mispredict_lane = 1'b0;
    #1;
    check("mp_grant", 32'(ifa.issue_grant), 32'h0);
    check("mp_flush", 32'({ifa.flush_dec, ifa.flush_issue}), 32'h3);
    check("mp_stall", 32'(ifa.stall_front), 32'h0);
    tick();
    clear_a();
    ifa.mispredict = 1'b1;
    #1;
    check("fl_grant", 32'(ifa.issue_grant), 32'h0);
    check("fl_flush", 32'({ifa.flush_dec, ifa.flush_issue}), 32'h3);
    tick();
    clear_a();
    lane_a(0, 22, 4, 0, 1, 0, 0, 0);
    #1;
    check("post_flush", 32'({ifa.flush_dec, ifa.flush_issue}), 32'h0);
    check("post_grant", 32'(ifa.issue_grant), 32'h1);
    check("post_sel_x4", 32'(ifa.fwd_sel_rs1[2:0]), 32'h0);
    check("post_count", ifa.stall_cycles, 32'h2);
    tick();

    // Reset in the middle of FLUSH; x22 sits in the shadow beforehand.
    clear_a();
    ifa.mispredict = 1'b1;
    #1;
    check("mp2_flush", 32'({ifa.flush_dec, ifa.flush_issue}), 32'h3);
    tick();
    clear_a();
    rst_a = 1'b1;
    #1;
    check("rstfl_grant", 32'(ifa.issue_grant), 32'h0);
    check("rstfl_flush", 32'({ifa.flush_dec, ifa.flush_issue}), 32'h0);
    tick();
    rst_a = 1'b0;
    lane_a(0, 23, 22, 0, 1, 0, 0, 0);
    #1;
    check("after_flush", 32'({ifa.flush_dec, ifa.flush_issue}), 32'h0);
    check("after_grant", 32'(ifa.issue_grant), 32'h1);
    check("after_sel", 32'(ifa.fwd_sel_rs1[2:0]), 32'h0);
    check("after_count", ifa.stall_cycles, 32'h0);
    check("after_stall", 32'(ifa.stall_front), 32'h0);
    clear_a();

    // Wide configuration: two memory ports allow two loads.
    lane_b(0, 1, 20, 0, 1, 1, 0, 0);
    lane_b(1, 2, 20, 0, 1, 1, 0, 0);
    lane_b(2, 3, 20, 0, 1, 1, 0, 0);
    lane_b(3, 5, 20, 0, 1, 1, 0, 0);
    #1;
    check("b_ld_grant", 32'(ifb.issue_grant), 32'h3);
    check("b_ld_stall", 32'(ifb.stall_front), 32'h1);
    clear_b();
    lane_b(0, 10, 1, 2, 1, 0, 0, 0);
    lane_b(1, 11, 1, 2, 1, 0, 0, 0);
    lane_b(2, 12, 1, 2, 1, 0, 0, 0);
    lane_b(3, 9, 5, 6, 1, 0, 0, 0);
    #1;
    check("b_alu_grant", 32'(ifb.issue_grant), 32'hF);
    tick();
    clear_b();
    tick();
    tick();
    tick();
    lane_b(0, 17, 9, 0, 1, 0, 0, 0);
    #1;
    check("b_s3_grant", 32'(ifb.issue_grant), 32'h1);
    check("b_s3_sel", 32'(ifb.fwd_sel_rs1[4:0]), 32'd16);
    check("b_s3_rs2", 32'(ifb.fwd_sel_rs2[4:0]), 32'd0);
    clear_b();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
